// File: rtl/logic_cmd_sequencer.sv
// Command sequencer for the 8-bit logic unit: queues (op, a, b) commands, drives the unit, returns tagged results.
// Optional RESULT_PARITY_EN adds res_parity_out (even-parity bit of the captured result).

// state | meaning
// IDLE  | no result pending, waiting for a queued command
// DRIVE | lu_* presented to the logic unit, result captured this cycle
// HOLD  | result presented on res_*, waiting for res_ready_in
module logic_cmd_sequencer #(
  parameter int DATA_WIDTH  = 8,
  parameter int OPCODE_SIZE = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   cmd_valid_in,
  output logic                   cmd_ready_out,
  input  logic [OPCODE_SIZE-1:0] cmd_op_in,
  input  logic [DATA_WIDTH-1:0]  cmd_a_in,
  input  logic [DATA_WIDTH-1:0]  cmd_b_in,
  output logic [DATA_WIDTH-1:0]  lu_a_out,
  output logic [DATA_WIDTH-1:0]  lu_b_out,
  output logic [OPCODE_SIZE-1:0] lu_op_out,
  input  logic [DATA_WIDTH-1:0]  lu_y_in,
  output logic                   res_valid_out,
  input  logic                   res_ready_in,
  output logic [DATA_WIDTH-1:0]  res_data_out,
`ifdef RESULT_PARITY_EN
  output logic                   res_parity_out,
`endif
  output logic [OPCODE_SIZE-1:0] res_op_out
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [OPCODE_SIZE-1:0] fifo_op [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]  fifo_a  [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]  fifo_b  [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr, rd_ptr;
  logic [PTR_W:0]         count;

  logic full, empty, push, pop;
  logic load_lu, capture, release_res;

  assign full          = (count == FULL_CNT);
  assign empty         = (count == '0);
  // Ready depends only on registered occupancy (and reset), never on cmd_valid_in.
  assign cmd_ready_out = ~rst_in & ~full;
  assign push          = cmd_valid_in & cmd_ready_out;

  always_ff @(posedge clk_in) begin
    if (push) begin
      fifo_op[wr_ptr] <= cmd_op_in;
      fifo_a[wr_ptr]  <= cmd_a_in;
      fifo_b[wr_ptr]  <= cmd_b_in;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    load_lu     = 1'b0;
    capture     = 1'b0;
    release_res = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          load_lu = 1'b1;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        capture = 1'b1;
        state_d = HOLD;
      end
      HOLD: begin
        if (res_ready_in) begin
          release_res = 1'b1;
          if (!empty) begin
            pop     = 1'b1;
            load_lu = 1'b1;
            state_d = DRIVE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // lu_* are deliberately not cleared between commands; they keep the last operands.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      lu_a_out      <= '0;
      lu_b_out      <= '0;
      lu_op_out     <= '0;
      res_valid_out <= 1'b0;
      res_data_out  <= '0;
      res_op_out    <= '0;
    end else begin
      if (load_lu) begin
        lu_a_out  <= fifo_a[rd_ptr];
        lu_b_out  <= fifo_b[rd_ptr];
        lu_op_out <= fifo_op[rd_ptr];
      end
      if (capture) begin
        res_data_out  <= lu_y_in;
        res_op_out    <= lu_op_out;
        res_valid_out <= 1'b1;
      end else if (release_res) begin
        res_valid_out <= 1'b0;
      end
    end
  end

`ifdef RESULT_PARITY_EN
  always_ff @(posedge clk_in) begin
    if (rst_in)       res_parity_out <= 1'b0;
    else if (capture) res_parity_out <= ^lu_y_in;
  end
`endif

endmodule

// File: tb/tb_logic_cmd_sequencer.sv
// Directed bench for logic_cmd_sequencer with a behavioural logic unit on the lu_* side.
// Define RESULT_PARITY_EN to also exercise res_parity_out.
module tb_logic_cmd_sequencer;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic       cmd_valid_in;
  logic       cmd_ready_out;
  logic [1:0] cmd_op_in;
  logic [7:0] cmd_a_in;
  logic [7:0] cmd_b_in;
  logic [7:0] lu_a_out;
  logic [7:0] lu_b_out;
  logic [1:0] lu_op_out;
  logic [7:0] lu_y_in;
  logic       res_valid_out;
  logic       res_ready_in;
  logic [7:0] res_data_out;
  logic [1:0] res_op_out;
`ifdef RESULT_PARITY_EN
  logic       res_parity_out;
`endif

  logic       y_force_en;
  logic [7:0] y_force_val;

  logic [7:0] got_data[$];
  logic [1:0] got_op[$];
  int         got_cyc[$];
  int         cyc = 0;

  int n_checks = 0;
  int n_errors = 0;

  logic_cmd_sequencer dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .cmd_valid_in  (cmd_valid_in),
    .cmd_ready_out (cmd_ready_out),
    .cmd_op_in     (cmd_op_in),
    .cmd_a_in      (cmd_a_in),
    .cmd_b_in      (cmd_b_in),
    .lu_a_out      (lu_a_out),
    .lu_b_out      (lu_b_out),
    .lu_op_out     (lu_op_out),
    .lu_y_in       (lu_y_in),
    .res_valid_out (res_valid_out),
    .res_ready_in  (res_ready_in),
    .res_data_out  (res_data_out),
`ifdef RESULT_PARITY_EN
    .res_parity_out(res_parity_out),
`endif
    .res_op_out    (res_op_out)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [7:0] lu_f(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      2'b00:   return a | b;
      2'b01:   return a ^ b;
      2'b10:   return a & b;
      default: return ~a;
    endcase
  endfunction

  always_comb lu_y_in = y_force_en ? y_force_val : lu_f(lu_op_out, lu_a_out, lu_b_out);

  always @(posedge clk_in) cyc++;

  // Record every result handshake; inputs are stable at the falling edge.
  always @(negedge clk_in) begin
    if (!rst_in && res_valid_out && res_ready_in) begin
      got_data.push_back(res_data_out);
      got_op.push_back(res_op_out);
      got_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic clear_results();
    got_data.delete();
    got_op.delete();
    got_cyc.delete();
  endtask

  task automatic push_cmd(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b, output bit ok);
    cmd_valid_in = 1'b1;
    cmd_op_in    = op;
    cmd_a_in     = a;
    cmd_b_in     = b;
    ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (cmd_ready_out) begin
        tick();
        ok = 1'b1;
        break;
      end
      tick();
    end
    cmd_valid_in = 1'b0;
  endtask

  task automatic wait_results(input string tag, input int n, input int budget);
    for (int i = 0; i < budget && got_data.size() < n; i++) tick();
    check(tag, got_data.size(), n);
  endtask

  task automatic wait_res_valid(input string tag, input int budget);
    for (int i = 0; i < budget && !res_valid_out; i++) tick();
    check(tag, res_valid_out, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [1:0] e_op[6];
  logic [7:0] e_a[6];
  logic [7:0] e_b[6];
  bit         ok;
  int         accepted;

  initial begin
    rst_in       = 1'b1;
    cmd_valid_in = 1'b0;
    cmd_op_in    = '0;
    cmd_a_in     = '0;
    cmd_b_in     = '0;
    res_ready_in = 1'b0;
    y_force_en   = 1'b0;
    y_force_val  = '0;
    tick();
    tick();
    check("rst_cmd_ready", cmd_ready_out, 0);
    check("rst_res_valid", res_valid_out, 0);
    check("rst_res_data", res_data_out, 0);
    check("rst_res_op", res_op_out, 0);
    check("rst_lu", {lu_a_out, lu_b_out, lu_op_out}, 0);
    rst_in = 1'b0;
    #1;
    check("post_rst_cmd_ready", cmd_ready_out, 1);

    // Single command: latency k+1 for lu_*, k+2 for result
    res_ready_in = 1'b1;
    clear_results();
    cmd_valid_in = 1'b1;
    cmd_op_in    = 2'b00;
    cmd_a_in     = 8'hA5;
    cmd_b_in     = 8'h3C;
    tick();
    cmd_valid_in = 1'b0;
    check("t1_k_res_valid", res_valid_out, 0);
    tick();
    check("t1_k1_lu_a", lu_a_out, 8'hA5);
    check("t1_k1_lu_b", lu_b_out, 8'h3C);
    check("t1_k1_lu_op", lu_op_out, 2'b00);
    check("t1_k1_res_valid", res_valid_out, 0);
    tick();
    check("t1_k2_res_valid", res_valid_out, 1);
    check("t1_k2_res_data", res_data_out, 8'hBD);
    check("t1_k2_res_op", res_op_out, 2'b00);
    tick();
    check("t1_k3_res_valid", res_valid_out, 0);
    check("t1_count", got_data.size(), 1);
    tick();
    check("t1_lu_held", {lu_a_out, lu_b_out}, 16'hA53C);

    // Back-to-back: one result every 2 cycles
    clear_results();
    push_cmd(2'b01, 8'hA5, 8'h3C, ok);
    push_cmd(2'b10, 8'hA5, 8'h3C, ok);
    push_cmd(2'b11, 8'hA5, 8'h3C, ok);
    wait_results("t2_results", 3, 30);
    check("t2_d0", got_data[0], 8'h99);
    check("t2_d1", got_data[1], 8'h24);
    check("t2_d2", got_data[2], 8'h5A);
    check("t2_op0", got_op[0], 2'b01);
    check("t2_op1", got_op[1], 2'b10);
    check("t2_op2", got_op[2], 2'b11);
    check("t2_gap01", got_cyc[1] - got_cyc[0], 2);
    check("t2_gap12", got_cyc[2] - got_cyc[1], 2);

    // Capacity: FIFO_DEPTH+1 accepted with results stalled
    tick();
    res_ready_in = 1'b0;
    clear_results();
    accepted = 0;
    for (int i = 0; i < 6; i++) begin
      logic [1:0] op;
      logic [7:0] a, b;
      op = 2'(i % 4);
      a  = 8'(8'h11 * (i + 1));
      b  = 8'hC3 ^ 8'(i);
      push_cmd(op, a, b, ok);
      if (ok) begin
        e_op[accepted] = op;
        e_a[accepted]  = a;
        e_b[accepted]  = b;
        accepted++;
      end
    end
    check("t3_accepted", accepted, 5);
    check("t3_cmd_ready_full", cmd_ready_out, 0);
    res_ready_in = 1'b1;
    wait_results("t3_results", 5, 40);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t3_d%0d", i), got_data[i], lu_f(e_op[i], e_a[i], e_b[i]));
      check($sformatf("t3_op%0d", i), got_op[i], e_op[i]);
    end

    // Reset while HOLD with 3 queued
    tick();
    res_ready_in = 1'b0;
    clear_results();
    push_cmd(2'b00, 8'h01, 8'h02, ok);
    push_cmd(2'b01, 8'h03, 8'h04, ok);
    push_cmd(2'b10, 8'h05, 8'h06, ok);
    push_cmd(2'b11, 8'h07, 8'h08, ok);
    wait_res_valid("t4_hold", 10);
    rst_in = 1'b1;
    tick();
    check("t4_rst_res", {res_valid_out, res_data_out, res_op_out}, 0);
    check("t4_rst_lu", {lu_a_out, lu_b_out, lu_op_out}, 0);
    check("t4_rst_cmd_ready", cmd_ready_out, 0);
    rst_in = 1'b0;
    #1;
    check("t4_cmd_ready", cmd_ready_out, 1);
    res_ready_in = 1'b1;
    repeat (10) tick();
    check("t4_no_result", got_data.size(), 0);
    check("t4_res_valid", res_valid_out, 0);
    push_cmd(2'b10, 8'hF0, 8'h3C, ok);
    wait_results("t4_after", 1, 10);
    check("t4_after_data", got_data[0], 8'h30);
    check("t4_after_op", got_op[0], 2'b10);

    // Stall in HOLD: result held while lu_y_in wanders
    tick();
    res_ready_in = 1'b0;
    clear_results();
    push_cmd(2'b01, 8'h0F, 8'hFF, ok);
    wait_res_valid("t5_hold", 10);
    y_force_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      y_force_val = 8'(i * 8'h1D + 3);
      tick();
      check($sformatf("t5_data_c%0d", i), res_data_out, 8'hF0);
      check($sformatf("t5_op_c%0d", i), res_op_out, 2'b01);
      check($sformatf("t5_valid_c%0d", i), res_valid_out, 1);
    end
    y_force_en   = 1'b0;
    res_ready_in = 1'b1;
    wait_results("t5_release", 1, 10);
    check("t5_release_data", got_data[0], 8'hF0);

`ifdef RESULT_PARITY_EN
    tick();
    clear_results();
    push_cmd(2'b00, 8'hA5, 8'h3C, ok);
    wait_res_valid("t6_v0", 10);
    check("t6_data0", res_data_out, 8'hBD);
    check("t6_par0", res_parity_out, 0);
    tick();
    push_cmd(2'b11, 8'h01, 8'h00, ok);
    wait_res_valid("t6_v1", 10);
    check("t6_data1", res_data_out, 8'hFE);
    check("t6_par1", res_parity_out, 1);
`endif

    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
